// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit datapath: opcodes, field positions, FSM states, decoded op.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package isa_pkg;

  // Opcode encodings; 100/101/110 are reserved and skipped by the sequencer
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Field positions inside the instruction word (LSB of each field)
  localparam int OPC_LSB  = 13;
  localparam int R1_LSB   = 10;
  localparam int R2_LSB   = 7;
  localparam int R3_LSB   = 4;
  localparam int IMM7_LSB = 0;
  localparam int FIELD_W  = 3;
  localparam int IMM7_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  reg1;
    logic [2:0]  reg2;
    logic [2:0]  reg3;
    logic [15:0] imm;
  } dec_t;

  // Sign-extend the 7-bit I-type immediate to the datapath width
  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: 16-bit word -> decoded fields plus legal/halt flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is used.
module instr_decode
  import isa_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_t        dec_o,
  output logic        is_legal_o,
  output logic        is_halt_o
);

  logic [2:0] opc;
  assign opc = instr_i[OPC_LSB +: FIELD_W];

  // Split the word by opcode class; fields that do not apply to a class read as zero
  always_comb begin
    dec_o        = '0;
    is_legal_o   = 1'b0;
    is_halt_o    = 1'b0;
    dec_o.opcode = opc;
    dec_o.reg1   = instr_i[R1_LSB +: FIELD_W];
    dec_o.reg2   = instr_i[R2_LSB +: FIELD_W];
    case (opc)
      OP_ADD, OP_SUB: begin
        dec_o.reg3 = instr_i[R3_LSB +: FIELD_W];
        is_legal_o = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        dec_o.imm  = sext7(instr_i[IMM7_LSB +: IMM7_W]);
        is_legal_o = 1'b1;
      end
      OP_HALT: begin
        is_halt_o  = 1'b1;
      end
      default: begin
        // reserved opcode: neither legal nor halt
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/issue sequencer: fetches words, issues one decoded op at a time, stops on HALT.
// Latency: start -> mem_req next cycle; zero-wait fetch -> issue_valid next cycle; 2 cycles/op minimum.
// Backpressure: mem_req held until mem_valid; issue_valid and fields held until issue_ready.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_valid,
  input  logic [15:0]         mem_rdata,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [2:0]          opcode,
  output logic [2:0]          reg1,
  output logic [2:0]          reg2,
  output logic [2:0]          reg3,
  output logic [15:0]         imm,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic [7:0]          illegal_cnt
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          illegal_q, illegal_d;
  dec_t                dec_q, dec_d;

  dec_t dec_w;
  logic is_legal_w;
  logic is_halt_w;

  instr_decode u_decode (
    .instr_i    (mem_rdata),
    .dec_o      (dec_w),
    .is_legal_o (is_legal_w),
    .is_halt_o  (is_halt_w)
  );

  // State, pc, counter and decoded-field registers; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      illegal_q <= '0;
      dec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      dec_q     <= dec_d;
    end
  end

  // Next-state logic: fetch until a legal word or HALT, then hold the op until accepted
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    dec_d     = dec_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        if (mem_valid) begin
          if (is_legal_w) begin
            dec_d   = dec_w;
            state_d = ST_ISSUE;
          end else if (is_halt_w) begin
            state_d = ST_HALTED;
          end else begin
            // reserved opcode: skip it in place, one fetch cycle each
            pc_d = pc_q + PC_WIDTH'(1);
            if (illegal_q != 8'hFF) begin
              illegal_d = illegal_q + 8'd1;
            end
          end
        end
      end
      ST_ISSUE: begin
        if (issue_ready) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_req     = (state_q == ST_FETCH);
  assign mem_addr    = mem_req ? pc_q : '0;
  assign issue_valid = (state_q == ST_ISSUE);
  assign opcode      = dec_q.opcode;
  assign reg1        = dec_q.reg1;
  assign reg2        = dec_q.reg2;
  assign reg3        = dec_q.reg3;
  assign imm         = dec_q.imm;
  assign pc          = pc_q;
  assign busy        = mem_req | issue_valid;
  assign halted      = (state_q == ST_HALTED);
  assign illegal_cnt = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: decode table, stall, reserved/halt, saturation, wrap, async reset.
// Latency: n/a.
// Backpressure: issue_ready randomised or hand-driven.
module tb_instr_sequencer;
  import isa_pkg::*;

  typedef struct packed {
    logic [2:0]  opc;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [2:0]  r3;
    logic [15:0] imm;
    logic [7:0]  pc;
  } exp_t;

  typedef struct {
    logic [15:0] word;
    bit          legal;
    logic [2:0]  opc;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [2:0]  r3;
    logic [15:0] imm;
  } vec_t;

  logic        clk, rst_n, start;
  logic        mem_req, mem_valid, issue_valid, issue_ready;
  logic [7:0]  mem_addr, pc, illegal_cnt;
  logic [15:0] mem_rdata, imm;
  logic [2:0]  opcode, reg1, reg2, reg3;
  logic        busy, halted;

  // narrow-pc instance for the wrap / async-reset scenario
  logic        w_rst_n, w_start, w_mem_req, w_mem_valid, w_issue_valid, w_issue_ready;
  logic        w_mem_en, w_busy, w_halted;
  logic [1:0]  w_mem_addr, w_pc;
  logic [15:0] w_mem_rdata, w_imm;
  logic [2:0]  w_opcode, w_reg1, w_reg2, w_reg3;
  logic [7:0]  w_illegal_cnt;
  logic [1:0]  w_addrs[$];

  int   n_vec = 0;
  int   n_err = 0;
  bit   auto_rdy = 0;
  exp_t sb_q[$];
  vec_t vecs[11];

  instr_sequencer #(.PC_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .reg1(reg1), .reg2(reg2), .reg3(reg3), .imm(imm),
    .pc(pc), .busy(busy), .halted(halted), .illegal_cnt(illegal_cnt)
  );

  instr_sequencer #(.PC_WIDTH(2)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .start(w_start),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_valid(w_mem_valid), .mem_rdata(w_mem_rdata),
    .issue_valid(w_issue_valid), .issue_ready(w_issue_ready),
    .opcode(w_opcode), .reg1(w_reg1), .reg2(w_reg2), .reg3(w_reg3), .imm(w_imm),
    .pc(w_pc), .busy(w_busy), .halted(w_halted), .illegal_cnt(w_illegal_cnt)
  );

  // zero-wait memory for the narrow instance, always returning an ADD word
  assign w_mem_valid = w_mem_en & w_mem_req;
  assign w_mem_rdata = 16'h0530;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input vec_t v, input logic [7:0] p);
    exp_t e;
    e = '{opc: v.opc, r1: v.r1, r2: v.r2, r3: v.r3, imm: v.imm, pc: p};
    return e;
  endfunction

  // random ready when enabled; inputs change 1 time unit after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_rdy) issue_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard: every accepted issue must match the oldest expectation
  initial forever begin
    @(negedge clk);
    if (rst_n && issue_valid && issue_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL issue_unexpected: got opcode %0d pc %0d, none expected", opcode, pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("issue", 64'({opcode, reg1, reg2, reg3, imm, pc}), 64'(e));
      end
    end
  end

  // record every fetch address of the narrow instance
  initial forever begin
    @(negedge clk);
    if (w_mem_req && w_mem_valid) w_addrs.push_back(w_mem_addr);
  end

  task automatic do_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_to_req", 64'(mem_req), 64'd1);
  endtask

  // wait for a fetch, return one word zero-wait, push its expectation if it should issue
  task automatic serve(input logic [15:0] w, input bit legal, input exp_t e,
                       input logic [7:0] addr, input string nm);
    int n = 0;
    while (!mem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_fetch"}, 64'({mem_req, mem_addr}), 64'({1'b1, addr}));
    mem_valid = 1;
    mem_rdata = w;
    if (legal) sb_q.push_back(e);
    @(posedge clk); #1;
    mem_valid = 0;
  endtask

  initial begin
    logic seen_req;
    int   wexp[5];
    vec_t add_v;
    vec_t addi_v;

    vecs[0]  = '{16'h0530, 1, 3'd0, 3'd1, 3'd2, 3'd3, 16'h0000};
    vecs[1]  = '{16'h32FF, 1, 3'd1, 3'd4, 3'd5, 3'd0, 16'hFFFF};
    vecs[2]  = '{16'h3C05, 1, 3'd1, 3'd7, 3'd0, 3'd0, 16'h0005};
    vecs[3]  = '{16'h4F40, 1, 3'd2, 3'd3, 3'd6, 3'd0, 16'hFFC0};
    vecs[4]  = '{16'h77EF, 1, 3'd3, 3'd5, 3'd7, 3'd6, 16'h0000};
    vecs[5]  = '{16'h08FA, 1, 3'd0, 3'd2, 3'd1, 3'd7, 16'h0000};
    vecs[6]  = '{16'h39BF, 1, 3'd1, 3'd6, 3'd3, 3'd0, 16'h003F};
    vecs[7]  = '{16'h4000, 1, 3'd2, 3'd0, 3'd0, 3'd0, 16'h0000};
    vecs[8]  = '{16'hA123, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000};
    vecs[9]  = '{16'hC0FF, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000};
    vecs[10] = '{16'hE000, 0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000};
    wexp = '{0, 1, 2, 3, 0};
    add_v  = vecs[0];
    addi_v = vecs[1];

    rst_n = 1; w_rst_n = 1;
    start = 0; w_start = 0; mem_valid = 0; mem_rdata = 0;
    issue_ready = 0; w_issue_ready = 1; w_mem_en = 1;
    #1;
    rst_n = 0; w_rst_n = 0;
    #22;
    rst_n = 1; w_rst_n = 1;

    // reset state and idle without start
    @(negedge clk);
    chk("reset_outs", 64'({mem_req, mem_addr, issue_valid, opcode, reg1, reg2, reg3, imm,
                           pc, busy, halted, illegal_cnt}), 64'd0);
    seen_req = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req) seen_req = 1;
    end
    chk("idle_no_req", 64'(seen_req), 64'd0);

    // reserved word then HALT, then restart keeps the illegal count
    @(posedge clk); #1;
    do_start();
    serve(16'h8000, 0, '0, 8'd0, "rsv");
    chk("rsv_no_issue", 64'({issue_valid, illegal_cnt, mem_addr}), 64'({1'b0, 8'd1, 8'd1}));
    serve(16'hE000, 0, '0, 8'd1, "halt1");
    chk("halt1_state", 64'({halted, busy, mem_req, issue_valid, pc}), 64'({4'b1000, 8'd1}));
    do_start();
    chk("restart", 64'({mem_addr, illegal_cnt}), 64'({8'd0, 8'd1}));

    // decode table under random backpressure
    auto_rdy = 1;
    for (int i = 0; i < 11; i++) begin
      serve(vecs[i].word, vecs[i].legal, mk(vecs[i], 8'(i)), 8'(i), "vec");
    end
    chk("table_halt", 64'({halted, pc, illegal_cnt}), 64'({1'b1, 8'd10, 8'd3}));
    chk("table_sb_empty", 64'(sb_q.size()), 64'd0);

    // stall in ISSUE for 3 cycles with stray mem_valid, then accept
    auto_rdy = 0;
    issue_ready = 0;
    do_start();
    chk("restart2_cnt", 64'(illegal_cnt), 64'd3);
    serve(add_v.word, 1, mk(add_v, 8'd0), 8'd0, "stall");
    chk("zero_wait_issue", 64'(issue_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      issue_ready = 0;
      mem_valid = 1;
      mem_rdata = 16'hE000;
      @(negedge clk);
      chk("stall_hold", 64'({issue_valid, mem_req, opcode, reg1, reg2, reg3, imm, pc}),
          64'({1'b1, 1'b0, 3'd0, 3'd1, 3'd2, 3'd3, 16'h0000, 8'd0}));
      @(posedge clk); #1;
    end
    mem_valid = 0;
    issue_ready = 1;
    @(posedge clk); #1;
    issue_ready = 0;
    chk("after_accept", 64'({mem_req, mem_addr, pc}), 64'({1'b1, 8'd1, 8'd1}));
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_while_busy", 64'({mem_req, mem_addr}), 64'({1'b1, 8'd1}));
    auto_rdy = 1;
    serve(addi_v.word, 1, mk(addi_v, 8'd1), 8'd1, "addi");

    // back-to-back reserved words: one fetch cycle each, counter saturates, pc wraps
    begin
      int n = 0;
      while (!mem_req && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("sat_start", 64'({mem_req, mem_addr, illegal_cnt}), 64'({1'b1, 8'd2, 8'd3}));
    mem_valid = 1;
    mem_rdata = 16'hA000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rsv_1cyc", 64'({mem_addr, illegal_cnt}), 64'({8'd5, 8'd6}));
    repeat (257) begin
      @(posedge clk); #1;
    end
    mem_valid = 0;
    chk("sat_wrap", 64'({mem_req, mem_addr, illegal_cnt}), 64'({1'b1, 8'd6, 8'd255}));
    serve(16'hE000, 0, '0, 8'd6, "halt2");
    chk("halt2_state", 64'({halted, pc, illegal_cnt}), 64'({1'b1, 8'd6, 8'd255}));
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    // narrow pc: five fetches wrap 0,1,2,3,0; async reset in the middle of the next fetch
    w_start = 1;
    @(posedge clk); #1;
    w_start = 0;
    for (int k = 0; k < 100; k++) begin
      if (w_addrs.size() >= 5 && w_mem_req) break;
      @(posedge clk); #1;
    end
    chk("w_fetch_count", 64'(w_addrs.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < w_addrs.size()) chk("w_fetch_addr", 64'(w_addrs[k]), 64'(wexp[k]));
    end
    chk("w_pre_reset_req", 64'({w_mem_req, w_mem_addr}), 64'({1'b1, 2'd1}));
    w_mem_en = 0;
    #2;
    w_rst_n = 0;
    #1;
    chk("w_async_reset", 64'({w_mem_req, w_mem_addr, w_issue_valid, w_opcode, w_reg1, w_reg2,
                              w_reg3, w_imm, w_pc, w_busy, w_halted, w_illegal_cnt}), 64'd0);
    @(posedge clk); #1;
    w_rst_n = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Front-end sequencer for the 16-bit datapath. It fetches 16-bit instruction words from program memory over a request/valid handshake and decodes each word into opcode, register indices and a sign-extended immediate. It issues one decoded operation at a time to the register-file execute stage over a valid/ready handshake. It stops on a HALT instruction and skips reserved opcodes, counting them.

## Interface
Parameters:
- PC_WIDTH, 8, program-counter / memory-address width; PC wraps modulo 2^PC_WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins execution from PC 0 when in IDLE or HALTED
- mem_req  out  1  fetch request, held until mem_valid
- mem_addr  out  PC_WIDTH  fetch address, equal to the current PC while mem_req is high
- mem_valid  in  1  memory returns a word; may be high in the same cycle as mem_req (zero-wait)
- mem_rdata  in  16  instruction word, sampled when mem_req && mem_valid
- issue_valid  out  1  decoded operation presented
- issue_ready  in  1  execute stage accepts the operation
- opcode  out  3  decoded opcode
- reg1  out  3  destination register index
- reg2  out  3  first source register index
- reg3  out  3  second source register index (R-type only, else 0)
- imm  out  16  sign-extended immediate (I-type only, else 0)
- pc  out  PC_WIDTH  current program counter
- busy  out  1  high in FETCH or ISSUE
- halted  out  1  high in HALTED
- illegal_cnt  out  8  saturating count of reserved opcodes skipped

## Operation
Instruction format:
- [15:13] opcode
- [12:10] reg1
- [9:7] reg2
- R-type only: [6:4] reg3, [3:0] ignored
- I-type only: [6:0] imm7, sign-extended to 16 bits

Opcode classes:
- R-type: 000 ADD, 011 SUB
- I-type: 001 ADDI, 010 SUBI
- HALT: 111
- Reserved: 100, 101, 110

States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: all handshake outputs low. start → FETCH with pc=0.
- FETCH: mem_req=1, mem_addr=pc. On the mem_valid cycle, decode mem_rdata:
  - legal opcode → latch fields, go to ISSUE
  - HALT → HALTED, pc unchanged
  - reserved → pc+1, illegal_cnt+1 (saturates at 255), stay in FETCH
- ISSUE: issue_valid=1 with fields stable. On issue_ready, pc+1 and go to FETCH. Without issue_ready, hold all fields and pc.
- HALTED: halted=1, busy=0, mem_req=0. start → FETCH with pc=0. illegal_cnt is not cleared.

Boundary rules:
- start while busy is ignored.
- mem_valid outside FETCH is ignored.
- pc wraps from 2^PC_WIDTH−1 to 0 with no flag.
- rst_n low at any time forces IDLE immediately and asynchronously: mem_req, issue_valid and every output drop to 0 with no wait for handshake completion.

## Timing
- Reset value of every output is 0; state IDLE, pc 0, illegal_cnt 0.
- start registered → mem_req high the next cycle.
- Zero-wait memory: word captured at the edge ending the first FETCH cycle; issue_valid high the following cycle.
- Minimum throughput is 2 cycles per issued instruction (FETCH, then ISSUE with ready=1).
- Each reserved opcode costs 1 FETCH cycle.
- Decoded output fields are registered and change only when entering ISSUE.

## Structure
- Shared package isa_pkg holds:
  - opcode constants OP_ADD, OP_ADDI, OP_SUBI, OP_SUB, OP_HALT
  - field bit-position constants
  - state enum typedef
  - decoded-instruction struct typedef (opcode, reg1–reg3, imm)
- The execute stage imports the same opcode constants from isa_pkg.
- One combinational sub-module, instr_decode: 16-bit word → decoded struct plus is_legal and is_halt flags.
- The FSM, pc and counter live in instr_sequencer.

## Test plan
- Reset, then idle with no start → every output 0, mem_req never asserted.
- start; mem word 0x0530 (ADD) → opcode 000, reg1 1, reg2 2, reg3 3, imm 0x0000, pc 0; after issue_ready, mem_addr 1.
- mem word 0x32FF (ADDI, imm7 0x7F) → opcode 001, reg1 4, reg2 5, reg3 0, imm 0xFFFF.
- issue_ready held low 3 cycles during ISSUE → all fields and pc stable, mem_req 0; ready high → pc increments by exactly 1.
- Word sequence 0x8000, then 0xE000 → no issue_valid, illegal_cnt 1, then halted=1 with pc 1; start → mem_addr 0, illegal_cnt still 1.
- PC_WIDTH=2, five ADD words, then rst_n pulsed low mid-FETCH → fetch addresses 0,1,2,3,0, then mem_req drops in the reset cycle and all outputs read 0.
